column_scheduler: RTL and testbench
===================================

# column_scheduler

Frame-level column sequencer for the raycasting renderer. On each frame start it walks screen columns 0..NUM_COLS-1 and reads each column's camera-plane X coordinate (Q8.8) from the camera-X ROM, which has one cycle of registered read latency. It then hands one column request at a time to the ray engine over a valid/ready handshake and waits for that column's completion before advancing. It sits between the frame timing logic and the per-column ray datapath, and is the only master of the camera-X ROM address.

## Interface
- NUM_COLS, 320, columns per frame; legal range 1..512.
- COL_W, 9, column index / ROM address width.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse that requests a new frame.
- rom_addr  out  COL_W  camera-X ROM address.
- rom_data  in  16  camera-X ROM output, Q8.8. It is valid one cycle after rom_addr.
- ray_valid  out  1  column request valid.
- ray_ready  in  1  ray engine accepts the request.
- ray_col  out  COL_W  column index of the request.
- ray_camerax  out  16  camera X of the request, Q8.8, passed through unmodified.
- col_done  in  1  one-cycle pulse: the ray engine finished the accepted column.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last column completes.
- overrun  out  1  one-cycle pulse when frame_start arrives while busy.

## Operation
- States: IDLE, FETCH, ROMWAIT, ISSUE, WAITDONE. The state is encoded in a register.
- col register, COL_W bits: rom_addr = col, and ray_col = col.
- IDLE:
  - frame_start=1 → col ← 0, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH: rom_addr holds col for this cycle. Unconditionally go to ROMWAIT.
- ROMWAIT: rom_data is now valid for col. Latch ray_camerax ← rom_data, go to ISSUE.
- ISSUE:
  - ray_valid=1. ray_col and ray_camerax stay stable until accepted.
  - ray_valid&ray_ready at the edge → go to WAITDONE.
  - ray_valid never drops before acceptance.
- WAITDONE: wait for col_done.
  - col_done and col==NUM_COLS-1 → pulse frame_done, go to IDLE.
  - col_done otherwise → col ← col+1, go to FETCH.
- col_done outside WAITDONE is ignored, including col_done in the same cycle as the ISSUE acceptance.
- frame_start outside IDLE does not restart or alter the current frame; it produces an overrun pulse instead.
- col never exceeds NUM_COLS-1. No wrap-around occurs, because the terminal column returns the FSM to IDLE.
- ROM contents are never modified. Addresses ≥ NUM_COLS are never issued.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - state=IDLE, col=0, rom_addr=0.
  - ray_valid=0, ray_col=0, ray_camerax=0.
  - busy=0, frame_done=0, overrun=0.
- Reset mid-frame aborts immediately: all outputs return to their reset values, including dropping ray_valid. Nothing resumes after release; the next frame_start begins at column 0.
- Column latency, with frame_start high in cycle t:
  - FETCH in t+1, ROMWAIT in t+2, ray_valid=1 in t+3.
- Per-column overhead: 3 cycles from the col_done edge to the next ray_valid (FETCH, ROMWAIT, then ISSUE). With ray_ready tied high and col_done returned k cycles after acceptance, each column takes 3+1+k cycles of steady-state period.
- frame_done is registered. It is high for exactly the one cycle in which the FSM is first back in IDLE. busy is 0 in that same cycle.
- frame_start in that first IDLE cycle is accepted as a new frame (no overrun).
- overrun is registered: it is high the cycle after the offending frame_start, one pulse per offending cycle.
- All outputs are driven from registers; there are no combinational paths from inputs to outputs.

## Test plan
- Reset and idle:
  - Stimulus: hold rst_n=0, release, wait 10 cycles with no frame_start.
  - Required: every output stays 0, and rom_addr stays 0.
- Full frame with a fast engine:
  - Stimulus: ROM model with camerax[i]=16'hFF00+i (any known table), ray_ready=1, col_done one cycle after each acceptance, frame_start pulse.
  - Required: exactly 320 handshakes with ray_col 0..319 in order. Each ray_camerax equals the ROM word for that column. frame_done pulses once after column 319. The frame lasts 1+320·5 cycles.
- Backpressure:
  - Stimulus: hold ray_ready=0 for 7 cycles on column 5.
  - Required: ray_valid stays 1, and ray_col=5 and ray_camerax stay stable throughout. Exactly one handshake occurs for column 5.
- Spurious inputs:
  - Stimulus: col_done in ISSUE and in IDLE; frame_start mid-frame at column 100.
  - Required: col_done pulses are ignored (no column skipped). overrun pulses once. The frame continues uninterrupted to column 319.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 while in ISSUE at column 42, release, then pulse frame_start.
  - Required: ray_valid drops asynchronously with reset. The new frame's first request is column 0.
- Back-to-back frames and NUM_COLS=1:
  - Stimulus: pulse frame_start in the frame_done cycle; separately, build with NUM_COLS=1.
  - Required: the second frame starts with no overrun. With NUM_COLS=1, a single column is requested at address 0, followed by frame_done.

Source files
------------

// File: rtl/column_scheduler.sv
// Frame-level column sequencer: walks columns 0..NUM_COLS-1, fetches each camera-plane X
// from the registered camera-X ROM and hands one request at a time to the ray engine.
module column_scheduler #(
    parameter int NUM_COLS = 320,
    parameter int COL_W    = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    output logic [COL_W-1:0] rom_addr,
    input  logic [15:0]      rom_data,
    output logic             ray_valid,
    input  logic             ray_ready,
    output logic [COL_W-1:0] ray_col,
    output logic [15:0]      ray_camerax,
    input  logic             col_done,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun
);
    typedef enum logic [2:0] {IDLE, FETCH, ROMWAIT, ISSUE, WAITDONE} state_t;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

    state_t           state;
    state_t           state_nx;
    logic [COL_W-1:0] col;
    logic [COL_W-1:0] col_nx;
    logic [15:0]      camx_nx;
    logic             fd_nx;

    always_comb begin
        state_nx = state;
        col_nx   = col;
        camx_nx  = ray_camerax;
        fd_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    col_nx   = '0;
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                state_nx = ROMWAIT;
            end
            ROMWAIT: begin
                camx_nx  = rom_data;
                state_nx = ISSUE;
            end
            ISSUE: begin
                // ray_valid is registered high for the whole of ISSUE, so ready alone completes the handshake
                if (ray_ready) begin
                    state_nx = WAITDONE;
                end
            end
            WAITDONE: begin
                if (col_done) begin
                    if (col == LAST_COL) begin
                        fd_nx    = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        col_nx   = col + COL_W'(1);
                        state_nx = FETCH;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so no input reaches an output combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            col         <= '0;
            ray_camerax <= '0;
            ray_valid   <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nx;
            col         <= col_nx;
            ray_camerax <= camx_nx;
            ray_valid   <= (state_nx == ISSUE);
            busy        <= (state_nx != IDLE);
            frame_done  <= fd_nx;
            overrun     <= frame_start && (state != IDLE);
        end
    end

    assign rom_addr = col;
    assign ray_col  = col;

endmodule

// File: tb/tb_column_scheduler.sv
// Randomized bench for column_scheduler: ROM and ray-engine models, transaction-level
// frame model and in-order handshake scoreboard; second instance built with NUM_COLS=1.
module tb_column_scheduler;
    localparam int N     = 320;
    localparam int COL_W = 9;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             frame_start = 1'b0;
    logic             ray_ready = 1'b0;
    logic             col_done = 1'b0;
    logic [COL_W-1:0] rom_addr;
    logic [COL_W-1:0] ray_col;
    logic [15:0]      rom_data;
    logic [15:0]      ray_camerax;
    logic             ray_valid;
    logic             busy;
    logic             frame_done;
    logic             overrun;

    logic             frame_start1 = 1'b0;
    logic             col_done1 = 1'b0;
    logic [COL_W-1:0] rom_addr1;
    logic [COL_W-1:0] ray_col1;
    logic [15:0]      rom_data1;
    logic [15:0]      ray_camerax1;
    logic             ray_valid1;
    logic             busy1;
    logic             frame_done1;
    logic             overrun1;

    logic [15:0] rom [512];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // stimulus / model state
    int rdy_mode = 0;   // 0: always ready, 1: random ready, 2: stall column 5 for 7 cycles
    int gap = 1;        // idle cycles between acceptance and col_done
    bit spur = 1'b0;    // inject col_done in ISSUE (columns 50..52) and in IDLE
    int bp_cnt = 0;
    int done_in = 0;
    int exp_col = 0;
    int ovr_cnt = 0;
    int m_ndone = 0;
    bit m_busy = 1'b0;
    bit m_fd = 1'b0;
    bit m_ovr = 1'b0;
    bit m_wait = 1'b0;

    column_scheduler #(.NUM_COLS(N), .COL_W(COL_W)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .ray_valid(ray_valid), .ray_ready(ray_ready), .ray_col(ray_col),
        .ray_camerax(ray_camerax), .col_done(col_done),
        .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    column_scheduler #(.NUM_COLS(1), .COL_W(COL_W)) dut1 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start1),
        .rom_addr(rom_addr1), .rom_data(rom_data1),
        .ray_valid(ray_valid1), .ray_ready(1'b1), .ray_col(ray_col1),
        .ray_camerax(ray_camerax1), .col_done(col_done1),
        .busy(busy1), .frame_done(frame_done1), .overrun(overrun1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // camera-X ROM with one cycle of registered read latency
    always @(posedge clk) begin
        rom_data  <= rom[rom_addr];
        rom_data1 <= rom[rom_addr1];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Engine model, scoreboard and frame model; inputs change here and are stable for the next edge
    always @(negedge clk) begin
        bit hs;
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_fd    = 1'b0;
            m_ovr   = 1'b0;
            m_wait  = 1'b0;
            m_ndone = 0;
            exp_col = 0;
            done_in = 0;
            col_done = 1'b0;
        end else begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("frame_done", 32'(frame_done), 32'(m_fd));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            if (overrun) ovr_cnt++;
            if (frame_done) begin
                chk("fd_cols", exp_col, N);
                exp_col = 0;
            end

            case (rdy_mode)
                0: ray_ready = 1'b1;
                1: ray_ready = ($urandom_range(3) != 0);
                default: begin
                    if ((bp_cnt == 0 && ray_valid && ray_col == 9'd5) || (bp_cnt > 0 && bp_cnt < 7)) begin
                        chk("bp_valid", 32'(ray_valid), 32'd1);
                        chk("bp_col", 32'(ray_col), 32'd5);
                        chk("bp_camx", 32'(ray_camerax), 32'(rom[5]));
                        ray_ready = 1'b0;
                        bp_cnt++;
                    end else begin
                        ray_ready = 1'b1;
                    end
                end
            endcase

            col_done = 1'b0;
            if (done_in > 0) begin
                done_in--;
                if (done_in == 0) col_done = 1'b1;
            end
            if (spur && ((ray_valid && ray_col >= 9'd50 && ray_col <= 9'd52) || !m_busy))
                col_done = 1'b1;

            hs = ray_valid && ray_ready;
            if (hs) begin
                chk("col_order", 32'(ray_col), exp_col);
                chk("camx", 32'(ray_camerax), 32'(rom[exp_col % 512]));
                chk("addr_rng", 32'(int'(rom_addr) < N), 32'd1);
                exp_col++;
                done_in = gap + 1;
            end

            // frame model: effect of the coming edge
            m_ovr = frame_start && m_busy;
            m_fd  = 1'b0;
            if (!m_busy) begin
                if (frame_start) begin
                    m_busy  = 1'b1;
                    m_ndone = 0;
                end
            end else if (m_wait && col_done) begin
                m_wait = 1'b0;
                m_ndone++;
                if (m_ndone == N) begin
                    m_busy = 1'b0;
                    m_fd   = 1'b1;
                end
            end
            if (hs) m_wait = 1'b1;
        end
    end

    // Called at posedge+1; returns at posedge+1 of the frame_done cycle
    task automatic run_frame(input bit chk_lat, input int inj, output int len);
        int t0;
        bit injd;
        bit got;
        frame_start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        frame_start = 1'b0;
        if (chk_lat) begin
            chk("lat1_vld", 32'(ray_valid), 32'd0);
            @(posedge clk); #1;
            chk("lat2_vld", 32'(ray_valid), 32'd0);
            @(posedge clk); #1;
            chk("lat3_vld", 32'(ray_valid), 32'd1);
            chk("lat3_col", 32'(ray_col), 32'd0);
        end
        injd = 1'b0;
        got  = 1'b0;
        for (int i = 0; i < 20000 && !got; i++) begin
            if (frame_done) begin
                got = 1'b1;
            end else begin
                frame_start = (inj >= 0) && !injd && ray_valid && (int'(ray_col) == inj);
                if (frame_start) injd = 1'b1;
                @(posedge clk); #1;
                frame_start = 1'b0;
            end
        end
        chk("fd_seen", 32'(got), 32'd1);
        len = cyc - t0;
    endtask

    initial begin : main
        int len;
        int base;
        bit got;
        for (int i = 0; i < 512; i++) rom[i] = 16'($urandom);

        #1;
        chk("rst_vld", 32'(ray_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_camx", 32'(ray_camerax), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outs", {28'd0, ray_valid, frame_done, overrun, busy}, 32'd0);
            chk("idle_addr", 32'(rom_addr), 32'd0);
            chk("idle_col", 32'(ray_col), 32'd0);
            chk("idle_camx", 32'(ray_camerax), 32'd0);
        end
        @(posedge clk); #1;

        // fast engine, exact frame length
        rdy_mode = 0;
        gap = 1;
        run_frame(1'b1, -1, len);
        chk("frame_len", len, 1 + N * 5);

        // back-to-back frame (started in the frame_done cycle) with backpressure on column 5
        rdy_mode = 2;
        bp_cnt = 0;
        run_frame(1'b0, -1, len);
        chk("frame_len_bp", len, 1 + N * 5 + 7);
        chk("bp_cycles", bp_cnt, 7);
        chk("b2b_no_ovr", ovr_cnt, 0);

        // spurious col_done, random ready and gap, frame_start mid-frame at column 100
        spur = 1'b1;
        rdy_mode = 1;
        gap = $urandom_range(3);
        repeat (5) @(posedge clk);
        #1;
        base = ovr_cnt;
        run_frame(1'b0, 100, len);
        chk("ovr_once", ovr_cnt - base, 1);
        spur = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // reset while column 42 is in ISSUE
        rdy_mode = 0;
        gap = 1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            if (ray_valid && ray_col == 9'd42) got = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("reach_c42", 32'(got), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(ray_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_col", 32'(ray_col), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(1'b1, -1, len);
        chk("frame_len_rst", len, 1 + N * 5);

        // single-column build
        frame_start1 = 1'b1;
        @(posedge clk); #1;
        frame_start1 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (ray_valid1) got = 1'b1;
        end
        chk("n1_vld", 32'(got), 32'd1);
        chk("n1_col", 32'(ray_col1), 32'd0);
        chk("n1_addr", 32'(rom_addr1), 32'd0);
        chk("n1_camx", 32'(ray_camerax1), 32'(rom[0]));
        @(posedge clk); #1;
        chk("n1_vld_drop", 32'(ray_valid1), 32'd0);
        col_done1 = 1'b1;
        @(posedge clk); #1;
        col_done1 = 1'b0;
        chk("n1_fd", 32'(frame_done1), 32'd1);
        chk("n1_busy", 32'(busy1), 32'd0);
        chk("n1_ovr", 32'(overrun1), 32'd0);
        @(posedge clk); #1;
        chk("n1_fd_pulse", 32'(frame_done1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
